// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-port integer register file with a
// per-register scoreboard. Issue logic reads operands and reserves
// destinations. Writeback writes results and clears the busy bits.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NRD*AW-1:0]   i_rnum,
  output logic [NRD*XLEN-1:0] o_rd,
  output logic [NRD-1:0]      o_rbusy,
  input  logic [NWR-1:0]      i_wen,
  input  logic [NWR*AW-1:0]   i_wnum,
  input  logic [NWR*XLEN-1:0] i_wd,
  input  logic                i_resv_en,
  input  logic [AW-1:0]       i_resv_num,
  output logic [NREG-1:0]     o_busy_vec
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;

  // Register storage: ports are visited in ascending order, so the
  // highest-numbered port targeting an index lands last and wins.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      regs <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (i_wen[p] && (i_wnum[p*AW +: AW] != '0)) begin
          regs[i_wnum[p*AW +: AW]] <= i_wd[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: writeback clears, then reserve overrides so a
  // new producer stays pending; bit 0 is forced clear.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (i_wen[p]) begin
        busy_d[i_wnum[p*AW +: AW]] = 1'b0;
      end
    end
    if (i_resv_en) begin
      busy_d[i_resv_num] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy_vec = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            busy;

    assign idx = i_rnum[k*AW +: AW];

    // Combinational read: stored value, optionally overridden by a
    // same-cycle write (highest port wins), forced to zero for x0 and
    // while reset is asserted.
    always_comb begin
      data = regs[idx];
      busy = busy_q[idx];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (i_wen[p] && (i_wnum[p*AW +: AW] == idx)) begin
            data = i_wd[p*XLEN +: XLEN];
            busy = 1'b0;
          end
        end
      end
      if ((idx == '0) || !i_rstn) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign o_rd[k*XLEN +: XLEN] = data;
    assign o_rbusy[k]           = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: drives two instances of the register file from the same
// stimulus. Instance A has two write ports with bypass, instance B has one
// write port (port 0 of the stimulus) without bypass. A behavioural model
// built from plain arrays predicts every read and the scoreboard.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rstn;
  logic [9:0]  rnum;
  logic [1:0]  wen;
  logic [9:0]  wnum;
  logic [63:0] wd;
  logic        resv_en;
  logic [4:0]  resv_num;

  logic [63:0] rd_a, rd_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [31:0] vec_a, vec_b;

  int checks;
  int errors;

  // Model state: index 0 = instance A, index 1 = instance B.
  logic [31:0] mem  [2][32];
  bit          busy [2][32];

  regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_rnum(rnum), .o_rd(rd_a), .o_rbusy(rbusy_a),
    .i_wen(wen), .i_wnum(wnum), .i_wd(wd), .i_resv_en(resv_en),
    .i_resv_num(resv_num), .o_busy_vec(vec_a)
  );

  regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_rnum(rnum), .o_rd(rd_b), .o_rbusy(rbusy_b),
    .i_wen(wen[0:0]), .i_wnum(wnum[4:0]), .i_wd(wd[31:0]), .i_resv_en(resv_en),
    .i_resv_num(resv_num), .o_busy_vec(vec_b)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) begin
        mem[d][r]  = 32'h0;
        busy[d][r] = 1'b0;
      end
    end
  endfunction

  // Architectural effect of one rising edge on each instance.
  function automatic void model_clock();
    int w;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ((d == 0) ? 2 : 1); p++) begin
        w = int'(wnum[p*5 +: 5]);
        if (wen[p] && w != 0) begin
          mem[d][w]  = wd[p*32 +: 32];
          busy[d][w] = 1'b0;
        end
      end
      if (resv_en && resv_num != 5'd0) busy[d][int'(resv_num)] = 1'b1;
    end
  endfunction

  // Expected read result for instance d at register idx under current inputs.
  function automatic void exp_read(input int d, input int idx,
                                   output logic [31:0] data, output logic b);
    data = mem[d][idx];
    b    = busy[d][idx];
    if (d == 0) begin
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && int'(wnum[p*5 +: 5]) == idx) begin
          data = wd[p*32 +: 32];
          b    = 1'b0;
        end
      end
    end
    if (idx == 0 || !rstn) begin
      data = 32'h0;
      b    = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_vec(input int d);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = busy[d][r];
    return v;
  endfunction

  function automatic logic [31:0] act_rd(input int d, input int k);
    return (d == 0) ? rd_a[k*32 +: 32] : rd_b[k*32 +: 32];
  endfunction

  function automatic logic act_rbusy(input int d, input int k);
    return (d == 0) ? rbusy_a[k] : rbusy_b[k];
  endfunction

  function automatic logic [31:0] act_vec(input int d);
    return (d == 0) ? vec_a : vec_b;
  endfunction

  task automatic set_idle();
    wen      = 2'b00;
    wnum     = 10'd0;
    wd       = 64'h0;
    resv_en  = 1'b0;
    resv_num = 5'd0;
  endtask

  // Let one rising edge happen, update the model, return on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] ed;
    logic eb;
    rstn = 1'b0;
    set_idle();
    rnum = 10'd0;
    model_reset();
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      rnum = {5'(r), 5'(31 - r)};
      wen  = 2'($urandom_range(0, 3));
      wnum = {5'(r), 5'(31 - r)};
      wd   = {$urandom, $urandom};
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++) begin
          exp_read(d, int'(rnum[k*5 +: 5]), ed, eb);
          checks++;
          if (act_rd(d, k) !== ed || act_rbusy(d, k) !== eb) begin
            errors++;
            $display("[TB] FAIL reset_read dut%0d port%0d x%0d: got %h/%b want %h/%b",
                     d, k, rnum[k*5 +: 5], act_rd(d, k), act_rbusy(d, k), ed, eb);
          end
        end
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_vec dut%0d: got %h want 0", d, act_vec(d));
      end
    end
    set_idle();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    wen  = 2'b01;
    wnum = {5'd0, 5'd5};
    wd   = {32'h0, 32'hDEADBEEF};
    rnum = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF || rbusy_a[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h/%b want deadbeef/0", rd_a[31:0], rbusy_a[0]);
    end
    checks++;
    if (rd_b[31:0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL nobypass_same_cycle: got %h want 0", rd_b[31:0]);
    end
    cycle();
    set_idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== 32'hDEADBEEF) begin
        errors++;
        $display("[TB] FAIL stored_x5 dut%0d: got %h want deadbeef", d, act_rd(d, 1));
      end
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] ed;
    logic eb;
    wen  = 2'b11;
    wnum = {5'd7, 5'd7};
    wd   = {32'h22, 32'h11};
    cycle();
    wnum = {5'd4, 5'd3};
    wd   = {32'hB, 32'hA};
    cycle();
    set_idle();
    rnum = {5'd3, 5'd7};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h22) begin
      errors++;
      $display("[TB] FAIL dual_same_idx: got %h want 22", rd_a[31:0]);
    end
    for (int i = 0; i < 2; i++) begin
      rnum = (i == 0) ? {5'd3, 5'd7} : {5'd4, 5'd3};
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++) begin
          exp_read(d, int'(rnum[k*5 +: 5]), ed, eb);
          checks++;
          if (act_rd(d, k) !== ed || act_rbusy(d, k) !== eb) begin
            errors++;
            $display("[TB] FAIL dual_write dut%0d port%0d x%0d: got %h/%b want %h/%b",
                     d, k, rnum[k*5 +: 5], act_rd(d, k), act_rbusy(d, k), ed, eb);
          end
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    resv_en  = 1'b1;
    resv_num = 5'd9;
    cycle();
    set_idle();
    rnum = {5'd9, 5'd9};
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d)[9] !== 1'b1 || act_rbusy(d, 0) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reserve_x9 dut%0d: got vec=%h rbusy=%b want bit9=1 rbusy=1",
                 d, act_vec(d), act_rbusy(d, 0));
      end
    end
    wen  = 2'b01;
    wnum = {5'd0, 5'd9};
    wd   = {32'h0, 32'h55};
    cycle();
    set_idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== exp_vec(d) || act_vec(d)[9] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL writeback_clear dut%0d: got %h want %h", d, act_vec(d), exp_vec(d));
      end
    end
    resv_en  = 1'b1;
    resv_num = 5'd9;
    wen      = 2'b01;
    wnum     = {5'd0, 5'd9};
    wd       = {32'h0, 32'h55};
    cycle();
    set_idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d)[9] !== 1'b1 || act_rd(d, 0) !== 32'h55 || act_rbusy(d, 0) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reserve_beats_write dut%0d: got vec=%h rd=%h rbusy=%b want bit9=1 rd=55 rbusy=1",
                 d, act_vec(d), act_rd(d, 0), act_rbusy(d, 0));
      end
    end
  endtask

  task automatic test_x0();
    wen      = 2'b11;
    wnum     = {5'd0, 5'd0};
    wd       = {32'hFFFFFFFF, 32'hFFFFFFFF};
    resv_en  = 1'b1;
    resv_num = 5'd0;
    rnum     = {5'd0, 5'd0};
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 0) !== 32'h0 || act_rbusy(d, 0) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL x0_same_cycle dut%0d: got %h/%b want 0/0", d, act_rd(d, 0), act_rbusy(d, 0));
      end
    end
    cycle();
    set_idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 1) !== 32'h0 || act_vec(d)[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL x0_after dut%0d: got rd=%h vec=%h want rd=0 bit0=0", d, act_rd(d, 1), act_vec(d));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic eb;
    for (int n = 0; n < 300; n++) begin
      wen      = 2'($urandom_range(0, 3));
      wnum     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd       = {$urandom, $urandom};
      resv_en  = 1'($urandom_range(0, 1));
      resv_num = 5'($urandom_range(0, 7));
      rnum     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++) begin
          exp_read(d, int'(rnum[k*5 +: 5]), ed, eb);
          checks++;
          if (act_rd(d, k) !== ed || act_rbusy(d, k) !== eb) begin
            errors++;
            $display("[TB] FAIL random_read n%0d dut%0d port%0d x%0d: got %h/%b want %h/%b",
                     n, d, k, rnum[k*5 +: 5], act_rd(d, k), act_rbusy(d, k), ed, eb);
          end
        end
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("[TB] FAIL random_vec n%0d dut%0d: got %h want %h", n, d, act_vec(d), exp_vec(d));
        end
      end
      cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    wen      = 2'b01;
    wnum     = {5'd0, 5'd10};
    wd       = {32'h0, 32'h1234};
    resv_en  = 1'b1;
    resv_num = 5'd11;
    cycle();
    set_idle();
    rnum = {5'd11, 5'd10};
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 0) !== 32'h1234 || act_vec(d)[11] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pre_reset dut%0d: got rd=%h vec=%h want rd=1234 bit11=1", d, act_rd(d, 0), act_vec(d));
      end
    end
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 0) !== 32'h0 || act_rbusy(d, 1) !== 1'b0 || act_vec(d) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL async_reset dut%0d: got rd=%h rbusy=%b vec=%h want all 0",
                 d, act_rd(d, 0), act_rbusy(d, 1), act_vec(d));
      end
    end
    wen      = 2'b01;
    wnum     = {5'd0, 5'd10};
    wd       = {32'h0, 32'hABCD};
    resv_en  = 1'b1;
    resv_num = 5'd11;
    cycle();
    set_idle();
    rstn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_rd(d, 0) !== 32'h0 || act_vec(d) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL write_in_reset dut%0d: got rd=%h vec=%h want 0/0", d, act_rd(d, 0), act_vec(d));
      end
    end
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_x0();
    test_random();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
